gates_result_checker: RTL

- Self-checking monitor that sits directly downstream of the two-input gates block.
- Samples the gate inputs a/b and the six gate outputs y0..y5 once each input vector has settled.
- Compares each output against the expected gate function, then accumulates check and error counts plus first-failure capture.
- Lets simulation and on-board bring-up report pass/fail without waveform inspection.

---
 rtl/gates_result_checker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gates_result_checker.sv
// gates_result_checker: monitor placed after the two-input gates block.
// Waits for each {a,b} vector to settle for SETTLE_CYC cycles, then checks
// y0..y5 against AND/NAND/OR/NOR/XOR/XNOR of a,b and accumulates results.
// Optional macro GATES_CHK_COVER_EN adds cov_mask (vectors compared) and
// makes pass also require full vector coverage.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset, waiting for start
// S_RUN  | checking; one compare per settled vector
// S_DONE | run ended by stop; results and pass held until next start
module gates_result_checker #(
   parameter int CNT_W      = 8,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             a,
   input  logic             b,
   input  logic             y0,
   input  logic             y1,
   input  logic             y2,
   input  logic             y3,
   input  logic             y4,
   input  logic             y5,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [5:0]       fail_mask,
   output logic             first_fail_vld,
`ifdef GATES_CHK_COVER_EN
   output logic [1:0]       first_fail_ab,
   output logic [3:0]       cov_mask
`else
   output logic [1:0]       first_fail_ab
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [1:0]       prev_ab;
   logic [3:0]       scnt;
   logic             cmp_done;

   logic [1:0]       ab;
   logic [5:0]       exp_y;
   logic [5:0]       mism;
   logic             any_mism;
   logic             cmp_fire;
   logic [CNT_W-1:0] chk_nxt;
   logic [CNT_W-1:0] err_nxt;
   logic [5:0]       mask_nxt;
   logic             pass_nxt;
`ifdef GATES_CHK_COVER_EN
   logic [3:0]       cov_hit;
   logic [3:0]       cov_nxt;
`endif

   // Expected gate outputs, mismatch vector and the results a compare this cycle would produce
   always_comb begin
      ab       = {a, b};
      exp_y    = {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
      mism     = exp_y ^ {y5, y4, y3, y2, y1, y0};
      any_mism = |mism;
      cmp_fire = (state == S_RUN) && (ab == prev_ab) && !cmp_done && (scnt == SETTLE_LAST);
      chk_nxt  = chk_cnt;
      err_nxt  = err_cnt;
      mask_nxt = fail_mask;
      if (cmp_fire) begin
         if (chk_cnt != CNT_MAX) chk_nxt = chk_cnt + CNT_ONE;
         if (any_mism) begin
            if (err_cnt != CNT_MAX) err_nxt = err_cnt + CNT_ONE;
            mask_nxt = fail_mask | mism;
         end
      end
`ifdef GATES_CHK_COVER_EN
      cov_hit     = 4'b0000;
      cov_hit[ab] = 1'b1;
      cov_nxt     = cmp_fire ? (cov_mask | cov_hit) : cov_mask;
      pass_nxt    = (err_nxt == '0) && (cov_nxt == 4'b1111);
`else
      pass_nxt    = (err_nxt == '0);
`endif
   end

   // Sequencer FSM plus settle tracking and result accumulation
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         prev_ab        <= 2'b00;
         scnt           <= 4'd0;
         cmp_done       <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         chk_cnt        <= '0;
         err_cnt        <= '0;
         fail_mask      <= 6'b0;
         first_fail_vld <= 1'b0;
         first_fail_ab  <= 2'b00;
`ifdef GATES_CHK_COVER_EN
         cov_mask       <= 4'b0000;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state          <= S_RUN;
                  busy           <= 1'b1;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  chk_cnt        <= '0;
                  err_cnt        <= '0;
                  fail_mask      <= 6'b0;
                  first_fail_vld <= 1'b0;
                  first_fail_ab  <= 2'b00;
                  prev_ab        <= ab;
                  scnt           <= 4'd0;
                  cmp_done       <= 1'b0;
`ifdef GATES_CHK_COVER_EN
                  cov_mask       <= 4'b0000;
`endif
               end
            end
            S_RUN: begin
               if (ab != prev_ab) begin
                  prev_ab  <= ab;
                  scnt     <= 4'd0;
                  cmp_done <= 1'b0;
               end else if (cmp_fire) begin
                  chk_cnt   <= chk_nxt;
                  err_cnt   <= err_nxt;
                  fail_mask <= mask_nxt;
                  cmp_done  <= 1'b1;
                  if (any_mism && !first_fail_vld) begin
                     first_fail_vld <= 1'b1;
                     first_fail_ab  <= ab;
                  end
`ifdef GATES_CHK_COVER_EN
                  cov_mask  <= cov_nxt;
`endif
               end else if (!cmp_done) begin
                  scnt <= scnt + 4'd1;
               end
               // stop wins over start; a compare due this same cycle is already folded into pass_nxt
               if (stop) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= pass_nxt;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
